// File: rtl/led_column_scanner.sv
// led_column_scanner: multiplexed LED-matrix column scanner.
// Scans the columns enabled by col_enable one at a time (one-hot col_drive),
// with BLANK_CYCLES of all-off dead time between columns. Row patterns,
// dwell time and status live in a zero-wait-state Avalon-MM slave.
// Optional macro LED_SCAN_PWM_EN adds a 4-bit brightness register at addr 7
// that gates row_drive with a 16-step PWM phase counter.
module led_column_scanner #(
  parameter int          NUM_COLS      = 5,
  parameter int          ROW_WIDTH     = 7,
  parameter logic [15:0] DWELL_DEFAULT = 16'd50000,
  parameter int          BLANK_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COLS-1:0]  col_enable,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic [NUM_COLS-1:0]  col_drive,
  output logic [ROW_WIDTH-1:0] row_drive,
  output logic                 frame_start
);

  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_BLANK    = 2'd1;
  localparam logic [1:0]  S_ON       = 2'd2;
  localparam logic [15:0] BLANK_LOAD = 16'(BLANK_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [2:0]           cur_col_q, cur_col_d;
  logic [15:0]          blank_q, blank_d;
  logic [15:0]          dwell_cnt_q, dwell_cnt_d;
  logic [15:0]          dwell_q, dwell_d;
  logic                 pend_q, pend_d;
  logic [NUM_COLS-1:0]  col_drive_q, col_drive_d;
  logic [ROW_WIDTH-1:0] row_drive_q, row_drive_d;
  logic                 fs_q, fs_d;
  logic [ROW_WIDTH-1:0] row_reg_q [NUM_COLS];
  logic [ROW_WIDTH-1:0] row_reg_d [NUM_COLS];

  logic                 wr;
  logic [2:0]           nxt_col, low_col, cand;
  logic                 nxt_wrap, found;
  logic                 row_gate;
  logic                 unused_wdata;

  assign wr           = chipselect && !write_n;
  assign unused_wdata = ^writedata[31:16];

  // Next enabled column after cur_col, wrapping; flags a wrap (incl. self-select).
  always_comb begin
    nxt_col  = cur_col_q;
    nxt_wrap = 1'b1;
    found    = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_COLS; i++) begin
      if (int'(cur_col_q) + i >= NUM_COLS) cand = 3'(int'(cur_col_q) + i - NUM_COLS);
      else                                 cand = 3'(int'(cur_col_q) + i);
      if (!found && col_enable[cand]) begin
        found    = 1'b1;
        nxt_col  = cand;
        nxt_wrap = (int'(cur_col_q) + i >= NUM_COLS);
      end
    end
  end

  // Lowest enabled column, used when leaving IDLE.
  always_comb begin
    low_col = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (col_enable[i]) low_col = 3'(i);
    end
  end

  // Register-file write decode.
  always_comb begin
    row_reg_d = row_reg_q;
    dwell_d   = dwell_q;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (wr && address == 3'(i)) row_reg_d[i] = writedata[ROW_WIDTH-1:0];
    end
    if (wr && address == 3'd5) dwell_d = writedata[15:0];
  end

  // Scan FSM: IDLE -> BLANK -> ON -> BLANK ..., with mask-change overrides.
  always_comb begin
    state_d     = state_q;
    cur_col_d   = cur_col_q;
    blank_d     = blank_q;
    dwell_cnt_d = dwell_cnt_q;
    pend_d      = pend_q;
    fs_d        = 1'b0;
    if (col_enable == '0) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_BLANK;
          cur_col_d = low_col;
          pend_d    = 1'b1;
          blank_d   = BLANK_LOAD;
        end
        S_BLANK: begin
          if (!col_enable[cur_col_q]) begin
            cur_col_d = nxt_col;
            pend_d    = pend_q | nxt_wrap;
            blank_d   = BLANK_LOAD;
          end else if (blank_q == '0) begin
            state_d     = S_ON;
            dwell_cnt_d = (dwell_q == '0) ? 16'd1 : dwell_q;
            fs_d        = pend_q;
            pend_d      = 1'b0;
          end else begin
            blank_d = blank_q - 16'd1;
          end
        end
        S_ON: begin
          if (!col_enable[cur_col_q] || dwell_cnt_q <= 16'd1) begin
            state_d   = S_BLANK;
            cur_col_d = nxt_col;
            pend_d    = pend_q | nxt_wrap;
            blank_d   = BLANK_LOAD;
          end else begin
            dwell_cnt_d = dwell_cnt_q - 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef LED_SCAN_PWM_EN
  logic [3:0] bright_q, bright_d;
  logic [3:0] phase_q, phase_d;

  // PWM phase restarts on ON entry so every column sees the same duty window.
  always_comb begin
    bright_d = (wr && address == 3'd7) ? writedata[3:0] : bright_q;
    phase_d  = (state_d == S_ON && state_q != S_ON) ? 4'd0 : phase_q + 4'd1;
    row_gate = (phase_d < bright_q);
  end

  // PWM registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bright_q <= 4'hF;
      phase_q  <= 4'd0;
    end else begin
      bright_q <= bright_d;
      phase_q  <= phase_d;
    end
  end
`else
  assign row_gate = 1'b1;
`endif

  // Outputs follow the next state so they line up with state_q cycle for cycle.
  always_comb begin
    col_drive_d = '0;
    row_drive_d = '0;
    if (state_d == S_ON) begin
      col_drive_d = NUM_COLS'(1) << cur_col_d;
      if (row_gate) row_drive_d = row_reg_d[cur_col_d];
    end
  end

  // State and register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_col_q   <= '0;
      blank_q     <= '0;
      dwell_cnt_q <= '0;
      dwell_q     <= DWELL_DEFAULT;
      pend_q      <= 1'b0;
      col_drive_q <= '0;
      row_drive_q <= '0;
      fs_q        <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) row_reg_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cur_col_q   <= cur_col_d;
      blank_q     <= blank_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_q     <= dwell_d;
      pend_q      <= pend_d;
      col_drive_q <= col_drive_d;
      row_drive_q <= row_drive_d;
      fs_q        <= fs_d;
      row_reg_q   <= row_reg_d;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    readdata = '0;
    case (address)
      3'd5: readdata[15:0] = dwell_q;
      3'd6: begin
        readdata[2:0] = cur_col_q;
        readdata[4]   = (state_q == S_ON);
        readdata[5]   = (state_q == S_BLANK);
      end
`ifdef LED_SCAN_PWM_EN
      3'd7: readdata[3:0] = bright_q;
`endif
      default: begin
        if (int'(address) < NUM_COLS) readdata[ROW_WIDTH-1:0] = row_reg_q[address];
      end
    endcase
  end

  assign col_drive   = col_drive_q;
  assign row_drive   = row_drive_q;
  assign frame_start = fs_q;

endmodule
